// File: rtl/mode_arbiter.sv
// mode_arbiter: shares the single front-panel output path (display/LED bus)
// between the info, ALU and PWM units. One owner at a time is picked round-robin
// (info -> alu -> pwm -> info). Each owner keeps the bus for a minimum time
// slice of QUANTUM cycles. Every change of owner passes through DEAD_CYCLES
// cycles with all grants low, so the output mux never drives two sources at once.
//
// Optional build macro: ALU_PRIORITY_EN
//   When defined, the ALU unit takes the bus as soon as it asks, and it keeps the
//   bus until req_alu drops. The rotation pointer only moves after info or pwm
//   ownership.
module mode_arbiter #(
  parameter int QUANTUM     = 8,
  parameter int DEAD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_info,
  input  logic       req_alu,
  input  logic       req_pwm,
  output logic       gnt_info,
  output logic       gnt_alu,
  output logic       gnt_pwm,
  output logic [1:0] sel,
  output logic       busy,
  output logic       new_grant
);

  // Slice counter width is derived from QUANTUM and is not meant to be overridden.
  localparam int CNT_W  = $clog2(QUANTUM + 1);
  localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);

  localparam logic [CNT_W-1:0]  SLICE_MAX = CNT_W'(QUANTUM - 1);
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_DEAD  = 2'd2
  } state_e;

  // Units are listed in rotation order.
  typedef enum logic [1:0] {
    U_INFO = 2'd0,
    U_ALU  = 2'd1,
    U_PWM  = 2'd2
  } unit_e;

  // Mux select codes seen by the output path.
  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_INFO = 2'b01;
  localparam logic [1:0] SEL_PWM  = 2'b10;
  localparam logic [1:0] SEL_ALU  = 2'b11;

  // Returns the unit that follows u in the rotation.
  function automatic unit_e succ(input unit_e u);
    unit_e n;
    case (u)
      U_INFO:  n = U_ALU;
      U_ALU:   n = U_PWM;
      default: n = U_INFO;
    endcase
    return n;
  endfunction

  // Returns the one-hot request/grant bit position of a unit: {pwm, alu, info}.
  function automatic logic [2:0] unit_mask(input unit_e u);
    logic [2:0] m;
    case (u)
      U_INFO:  m = 3'b001;
      U_ALU:   m = 3'b010;
      U_PWM:   m = 3'b100;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

  // Returns the first requesting unit at or after the pointer.
  // The caller makes sure that at least one request is high.
  function automatic unit_e pick(input logic [2:0] r, input unit_e p);
    unit_e c1;
    unit_e c2;
    unit_e w;
    c1 = succ(p);
    c2 = succ(c1);
    if (|(r & unit_mask(p))) begin
      w = p;
    end else if (|(r & unit_mask(c1))) begin
      w = c1;
    end else begin
      w = c2;
    end
    return w;
  endfunction

  state_e            state_q, state_d;
  unit_e             owner_q, owner_d;
  unit_e             ptr_q, ptr_d;
  logic [CNT_W-1:0]  slice_q, slice_d;
  logic [DEAD_W-1:0] dead_q, dead_d;
  logic [2:0]        gnt_q, gnt_d;
  logic [1:0]        sel_q, sel_d;
  logic              new_grant_q, new_grant_d;

  logic [2:0] req_vec;
  logic       any_req;
  logic       owner_req;
  logic       other_req;
  logic       slice_done;
  logic       preempt;
  unit_e      winner;
  unit_e      ptr_after;

  // Gather the requests and describe them relative to the current owner.
  always_comb begin
    req_vec    = {req_pwm, req_alu, req_info};
    any_req    = |req_vec;
    owner_req  = |(req_vec & unit_mask(owner_q));
    other_req  = |(req_vec & ~unit_mask(owner_q));
    slice_done = (slice_q == SLICE_MAX);
  end

  // Decide the arbitration policy: when to preempt, who wins, and where the pointer goes.
  always_comb begin
    preempt   = slice_done && other_req;
    winner    = pick(req_vec, ptr_q);
    ptr_after = succ(owner_q);
`ifdef ALU_PRIORITY_EN
    if (owner_q == U_ALU) begin
      // An ALU owner holds the bus until it lets go; the rotation does not move.
      preempt   = 1'b0;
      ptr_after = ptr_q;
    end else if (req_alu) begin
      preempt = 1'b1;
    end
    if (req_alu) begin
      winner = U_ALU;
    end
`endif
  end

  // Next-state logic for the IDLE / GRANT / DEAD ownership sequence.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through the case can infer a latch.
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    slice_d     = slice_q;
    dead_d      = dead_q;
    new_grant_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d     = S_GRANT;
          owner_d     = winner;
          slice_d     = '0;
          new_grant_d = 1'b1;
        end
      end

      S_GRANT: begin
        // Release and quantum expiry take the same path into DEAD.
        if (!owner_req || preempt) begin
          state_d = S_DEAD;
          dead_d  = DEAD_LOAD;
          ptr_d   = ptr_after;
        end else if (!slice_done) begin
          slice_d = slice_q + 1'b1;
        end
      end

      S_DEAD: begin
        if (dead_q != '0) begin
          dead_d = dead_q - 1'b1;
        end else if (any_req) begin
          state_d     = S_GRANT;
          owner_d     = winner;
          slice_d     = '0;
          new_grant_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Decode the next grant and mux select, so both are registered with the state.
  always_comb begin
    gnt_d = 3'b000;
    sel_d = SEL_NONE;
    if (state_d == S_GRANT) begin
      gnt_d = unit_mask(owner_d);
      case (owner_d)
        U_INFO:  sel_d = SEL_INFO;
        U_ALU:   sel_d = SEL_ALU;
        U_PWM:   sel_d = SEL_PWM;
        default: sel_d = SEL_NONE;
      endcase
    end
  end

  // State and output registers. Reset drops any grant at once, even in the middle of a slice.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      owner_q     <= U_INFO;
      ptr_q       <= U_INFO;
      slice_q     <= '0;
      dead_q      <= '0;
      gnt_q       <= 3'b000;
      sel_q       <= SEL_NONE;
      new_grant_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop take its new value together at the edge.
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      slice_q     <= slice_d;
      dead_q      <= dead_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      new_grant_q <= new_grant_d;
    end
  end

  assign gnt_info  = gnt_q[0];
  assign gnt_alu   = gnt_q[1];
  assign gnt_pwm   = gnt_q[2];
  assign sel       = sel_q;
  assign busy      = (state_q != S_IDLE);
  assign new_grant = new_grant_q;

endmodule

// File: tb/tb_mode_arbiter.sv
// Testbench for mode_arbiter with QUANTUM=4 and DEAD_CYCLES=1.
// Directed scenarios are followed by a randomized run. The random run is checked
// against a cycle-level ownership model written with plain integer arithmetic.
module tb_mode_arbiter;

  localparam int QUANTUM     = 4;
  localparam int DEAD_CYCLES = 1;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       req_info = 1'b0;
  logic       req_alu  = 1'b0;
  logic       req_pwm  = 1'b0;
  logic       gnt_info;
  logic       gnt_alu;
  logic       gnt_pwm;
  logic [1:0] sel;
  logic       busy;
  logic       new_grant;

  int checks = 0;
  int errors = 0;

  // Reference model state. Units: 0 info, 1 alu, 2 pwm. Owner -1 means nobody owns the bus.
  int m_owner;
  int m_age;
  int m_dead;
  int m_ptr;
  bit m_new;

  always #5 clk = ~clk;

  mode_arbiter #(
    .QUANTUM    (QUANTUM),
    .DEAD_CYCLES(DEAD_CYCLES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_info (req_info),
    .req_alu  (req_alu),
    .req_pwm  (req_pwm),
    .gnt_info (gnt_info),
    .gnt_alu  (gnt_alu),
    .gnt_pwm  (gnt_pwm),
    .sel      (sel),
    .busy     (busy),
    .new_grant(new_grant)
  );

  // Observed output bundle: {gnt_info, gnt_alu, gnt_pwm, sel, busy, new_grant}.
  function automatic logic [6:0] observed();
    return {gnt_info, gnt_alu, gnt_pwm, sel, busy, new_grant};
  endfunction

  // Expected output bundle for a given owner, built from the select encoding.
  function automatic logic [6:0] expect_vec(input int owner, input logic bsy, input logic ng);
    logic [4:0] gs;
    case (owner)
      0:       gs = 5'b100_01;
      1:       gs = 5'b010_11;
      2:       gs = 5'b001_10;
      default: gs = 5'b000_00;
    endcase
    return {gs, bsy, ng};
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_age   = 0;
    m_dead  = 0;
    m_ptr   = 0;
    m_new   = 1'b0;
  endtask

  // Advances the model by one clock edge, using the requests present at that edge.
  task automatic model_step();
    bit r [3];
    bit others;
    r[0]  = req_info;
    r[1]  = req_alu;
    r[2]  = req_pwm;
    m_new = 1'b0;
    if (!rst) begin
      model_reset();
    end else if (m_owner >= 0) begin
      others = 1'b0;
      for (int u = 0; u < 3; u++) begin
        if (u != m_owner && r[u]) others = 1'b1;
      end
      if (!r[m_owner] || (m_age >= QUANTUM - 1 && others)) begin
        m_ptr   = (m_owner + 1) % 3;
        m_owner = -1;
        m_dead  = DEAD_CYCLES;
      end else begin
        m_age++;
      end
    end else if (m_dead > 1) begin
      m_dead--;
    end else begin
      m_dead = 0;
      for (int k = 0; k < 3; k++) begin
        int u;
        u = (m_ptr + k) % 3;
        if (r[u] && m_owner < 0) begin
          m_owner = u;
          m_age   = 0;
          m_new   = 1'b1;
        end
      end
    end
  endtask

  // One clock: step the model at the edge, then settle 1 ns before sampling.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    req_info = 1'b0;
    req_alu  = 1'b0;
    req_pwm  = 1'b0;
    rst      = 1'b0;
    model_reset();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (observed() !== expect_vec(-1, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL reset_async: got %b want %b", observed(), expect_vec(-1, 1'b0, 1'b0));
    end
    req_info = 1'b1;
    tick();
    checks++;
    if (observed() !== expect_vec(-1, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL reset_held: got %b want %b", observed(), expect_vec(-1, 1'b0, 1'b0));
    end
    req_info = 1'b0;
    rst      = 1'b1;
    tick();
    checks++;
    if (observed() !== expect_vec(-1, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL reset_release: got %b want %b", observed(), expect_vec(-1, 1'b0, 1'b0));
    end
  endtask

  task automatic test_single();
    logic       pat  [6];
    logic [6:0] want [6];
    pat  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    want = '{expect_vec(0, 1, 1), expect_vec(0, 1, 0), expect_vec(0, 1, 0),
             expect_vec(-1, 1, 0), expect_vec(-1, 0, 0), expect_vec(-1, 0, 0)};
    for (int i = 0; i < 6; i++) begin
      req_info = pat[i];
      tick();
      checks++;
      if (observed() !== want[i]) begin
        errors++;
        $display("FAIL single[%0d]: got %b want %b", i, observed(), want[i]);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [6:0] want [11];
    want = '{expect_vec(0, 1, 1), expect_vec(0, 1, 0), expect_vec(0, 1, 0), expect_vec(0, 1, 0),
             expect_vec(-1, 1, 0),
             expect_vec(2, 1, 1), expect_vec(2, 1, 0), expect_vec(2, 1, 0), expect_vec(2, 1, 0),
             expect_vec(-1, 1, 0),
             expect_vec(0, 1, 1)};
    do_reset();
    req_info = 1'b1;
    req_pwm  = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      checks++;
      if (observed() !== want[i]) begin
        errors++;
        $display("FAIL simultaneous[%0d]: got %b want %b", i, observed(), want[i]);
      end
    end
    req_info = 1'b0;
    req_pwm  = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_hold();
    logic [6:0] want;
    req_alu = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      want = expect_vec(1, 1'b1, (i == 0));
      checks++;
      if (observed() !== want) begin
        errors++;
        $display("FAIL hold[%0d]: got %b want %b", i, observed(), want);
      end
    end
    req_alu = 1'b0;
    tick();
    tick();
    checks++;
    if (observed() !== expect_vec(-1, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL hold_idle: got %b want %b", observed(), expect_vec(-1, 1'b0, 1'b0));
    end
  endtask

  task automatic test_async_reset();
    req_pwm = 1'b1;
    repeat (3) tick();
    checks++;
    if (observed() !== expect_vec(2, 1'b1, 1'b0)) begin
      errors++;
      $display("FAIL async_owner: got %b want %b", observed(), expect_vec(2, 1'b1, 1'b0));
    end
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (observed() !== expect_vec(-1, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL async_drop: got %b want %b", observed(), expect_vec(-1, 1'b0, 1'b0));
    end
    #2;
    rst = 1'b1;
    tick();
    checks++;
    if (observed() !== expect_vec(2, 1'b1, 1'b1)) begin
      errors++;
      $display("FAIL async_regrant: got %b want %b", observed(), expect_vec(2, 1'b1, 1'b1));
    end
    req_pwm = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_release_dead();
    // Stimulus bits are {info, alu, pwm}.
    logic [2:0] stim [10];
    logic [6:0] want [10];
    stim = '{3'b100, 3'b110, 3'b110, 3'b110, 3'b110, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000};
    want = '{expect_vec(0, 1, 1), expect_vec(0, 1, 0), expect_vec(0, 1, 0), expect_vec(0, 1, 0),
             expect_vec(-1, 1, 0), expect_vec(-1, 0, 0), expect_vec(-1, 0, 0),
             expect_vec(0, 1, 1), expect_vec(-1, 1, 0), expect_vec(-1, 0, 0)};
    for (int i = 0; i < 10; i++) begin
      req_info = stim[i][2];
      req_alu  = stim[i][1];
      req_pwm  = stim[i][0];
      tick();
      checks++;
      if (observed() !== want[i]) begin
        errors++;
        $display("FAIL release_dead[%0d]: got %b want %b", i, observed(), want[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] want;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(5) == 0) req_info = ~req_info;
      if ($urandom_range(5) == 0) req_alu  = ~req_alu;
      if ($urandom_range(5) == 0) req_pwm  = ~req_pwm;
      if ($urandom_range(199) == 0) begin
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (observed() !== expect_vec(-1, 1'b0, 1'b0)) begin
          errors++;
          $display("FAIL random_reset[%0d]: got %b want %b", i, observed(), expect_vec(-1, 1'b0, 1'b0));
        end
        #1;
        rst = 1'b1;
      end
      tick();
      want = expect_vec(m_owner, (m_owner >= 0 || m_dead > 0), m_new);
      checks++;
      if (observed() !== want) begin
        errors++;
        $display("FAIL random[%0d]: got %b want %b (req i/a/p %b%b%b)",
                 i, observed(), want, req_info, req_alu, req_pwm);
      end
    end
    req_info = 1'b0;
    req_alu  = 1'b0;
    req_pwm  = 1'b0;
    repeat (3) tick();
  endtask

`ifdef ALU_PRIORITY_EN
  task automatic test_alu_priority();
    logic [2:0] stim [14];
    logic [6:0] want [14];
    stim[0] = 3'b100;
    stim[1] = 3'b100;
    stim[2] = 3'b110;
    stim[3] = 3'b110;
    want[0] = expect_vec(0, 1, 1);
    want[1] = expect_vec(0, 1, 0);
    want[2] = expect_vec(-1, 1, 0);
    want[3] = expect_vec(1, 1, 1);
    for (int i = 4; i < 14; i++) begin
      stim[i] = 3'b111;
      want[i] = expect_vec(1, 1, 0);
    end
    do_reset();
    for (int i = 0; i < 14; i++) begin
      req_info = stim[i][2];
      req_alu  = stim[i][1];
      req_pwm  = stim[i][0];
      tick();
      checks++;
      if (observed() !== want[i]) begin
        errors++;
        $display("FAIL alu_priority[%0d]: got %b want %b", i, observed(), want[i]);
      end
    end
    req_info = 1'b0;
    req_alu  = 1'b0;
    req_pwm  = 1'b0;
    repeat (3) tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_hold();
    test_async_reset();
`ifdef ALU_PRIORITY_EN
    test_alu_priority();
`else
    test_simultaneous();
    test_release_dead();
    test_random();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
